// File: rtl/dsp_mac_pkg.sv
// Shared constants and helpers for the N-lane multiply / multiply-accumulate.
// Product width rule and ACC_WIDTH extension live here so every lane agrees.
package dsp_mac_pkg;

  localparam int MIN_LATENCY = 3;
  // Widest accumulator the extension helper can carry.
  localparam int MAX_W = 128;

  function automatic int prod_width(input int xw, input int yw);
    return xw + yw;
  endfunction

  // Extend a prod_w-bit product to acc_width bits; bits above acc_width are zero.
  function automatic logic [MAX_W-1:0] ext_prod(
    input logic [MAX_W-1:0] prod,
    input int               prod_w,
    input bit               signed_mode,
    input int               acc_width
  );
    logic [MAX_W-1:0] r;
    logic             s;
    s = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == prod_w - 1) s = prod[i] & signed_mode;
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i < prod_w)         r[i] = prod[i];
      else if (i < acc_width) r[i] = s;
      else                    r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One MAC channel: input register, LATENCY-2 product stages, accumulator; LATENCY enabled cycles.
// No backpressure; ena freezes every register, sclr has priority over ena.
module dsp_mac_lane
  import dsp_mac_pkg::*;
#(
  parameter string FAMILY    = "Agilex",
  parameter int    X_WIDTH   = 18,
  parameter int    Y_WIDTH   = 18,
  parameter bit    SIGNED    = 1'b0,
  parameter int    ACC_WIDTH = 44,
  parameter int    LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 ena,
  input  logic [X_WIDTH-1:0]   x,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic                 acc_en,
  input  logic                 acc_load,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 overflow
);

  localparam int PW = prod_width(X_WIDTH, Y_WIDTH);
  localparam int NP = LATENCY - 2;

  if (FAMILY == "") begin : g_bad_family
    $fatal(1, "dsp_mac_lane: FAMILY must name a device family");
  end

  logic [X_WIDTH-1:0]   x_r;
  logic [Y_WIDTH-1:0]   y_r;
  logic [PW-1:0]        prod;
  logic [PW-1:0]        p_pipe [NP];
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   sum_c;
  logic                 add_ovf;

  // Operands are widened to the full product width before multiplying.
  if (SIGNED) begin : g_smul
    assign prod = PW'($signed(x_r)) * PW'($signed(y_r));
  end else begin : g_umul
    assign prod = PW'(x_r) * PW'(y_r);
  end

  assign addend = ACC_WIDTH'(ext_prod(MAX_W'(p_pipe[NP-1]), PW, SIGNED, ACC_WIDTH));
  assign sum_c  = {1'b0, acc} + {1'b0, addend};

  always_comb begin
    add_ovf = 1'b0;
    if (SIGNED)
      add_ovf = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                (sum_c[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    else
      add_ovf = sum_c[ACC_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      x_r      <= '0;
      y_r      <= '0;
      for (int i = 0; i < NP; i++) p_pipe[i] <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      x_r       <= x;
      y_r       <= y;
      p_pipe[0] <= prod;
      for (int i = 1; i < NP; i++) p_pipe[i] <= p_pipe[i-1];
      if (acc_en) begin
        if (acc_load) begin
          acc      <= addend;
          overflow <= 1'b0;
        end else begin
          acc      <= sum_c[ACC_WIDTH-1:0];
          overflow <= overflow | add_ovf;
        end
      end
    end
  end

endmodule

// File: rtl/dsp_n_mult_acc.sv
// CHANNELS-lane multiply / multiply-accumulate; dout LATENCY-1 enabled edges after the input edge.
// No backpressure: a sample every enabled cycle; lanes share valid/load/ena and stay aligned.
module dsp_n_mult_acc
  import dsp_mac_pkg::*;
#(
  parameter string FAMILY    = "Agilex",
  parameter int    CHANNELS  = 2,
  parameter int    X_WIDTH   = 18,
  parameter int    Y_WIDTH   = 18,
  parameter bit    SIGNED    = 1'b0,
  parameter int    ACC_WIDTH = 44,
  parameter int    LATENCY   = 4
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic                          ena,
  input  logic                          din_valid,
  input  logic                          din_load,
  input  logic [CHANNELS*X_WIDTH-1:0]   x,
  input  logic [CHANNELS*Y_WIDTH-1:0]   y,
  output logic                          dout_valid,
  output logic [CHANNELS*ACC_WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]           overflow
);

  if (CHANNELS < 1) begin : g_bad_channels
    $fatal(1, "dsp_n_mult_acc: CHANNELS must be >= 1");
  end
  if (LATENCY < MIN_LATENCY) begin : g_bad_latency
    $fatal(1, "dsp_n_mult_acc: LATENCY must be >= %0d", MIN_LATENCY);
  end
  if (ACC_WIDTH < prod_width(X_WIDTH, Y_WIDTH)) begin : g_bad_acc
    $fatal(1, "dsp_n_mult_acc: ACC_WIDTH must be >= X_WIDTH+Y_WIDTH");
  end
  if (ACC_WIDTH > MAX_W) begin : g_wide_acc
    $fatal(1, "dsp_n_mult_acc: ACC_WIDTH must be <= %0d", MAX_W);
  end

  // Bit i tracks stage i+1; the top valid bit is the accumulator stage itself.
  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-2:0] ld_sr;

  always_ff @(posedge clk) begin
    if (sclr) begin
      vld_sr <= '0;
      ld_sr  <= '0;
    end else if (ena) begin
      vld_sr <= {vld_sr[LATENCY-2:0], din_valid};
      ld_sr  <= {ld_sr[LATENCY-3:0], din_load};
    end
  end

  assign dout_valid = vld_sr[LATENCY-1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    dsp_mac_lane #(
      .FAMILY   (FAMILY),
      .X_WIDTH  (X_WIDTH),
      .Y_WIDTH  (Y_WIDTH),
      .SIGNED   (SIGNED),
      .ACC_WIDTH(ACC_WIDTH),
      .LATENCY  (LATENCY)
    ) u_lane (
      .clk     (clk),
      .sclr    (sclr),
      .ena     (ena),
      .x       (x[i*X_WIDTH +: X_WIDTH]),
      .y       (y[i*Y_WIDTH +: Y_WIDTH]),
      .acc_en  (vld_sr[LATENCY-2]),
      .acc_load(ld_sr[LATENCY-2]),
      .acc     (dout[i*ACC_WIDTH +: ACC_WIDTH]),
      .overflow(overflow[i])
    );
  end

endmodule

// File: tb/tb_dsp_n_mult_acc.sv
// Three instances share control: 4-lane unsigned/44b (lanes 0-3), signed/44b (lane 4), unsigned/36b (lane 5).
module tb_dsp_n_mult_acc;

  localparam int L = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic sclr, ena, din_valid, din_load;
  logic [17:0] bx [6];
  logic [17:0] by [6];

  logic [71:0]  x_u, y_u;
  logic [17:0]  x_s, y_s, x_o, y_o;
  logic         dv_u, dv_s, dv_o;
  logic [175:0] dout_u;
  logic [43:0]  dout_s;
  logic [35:0]  dout_o;
  logic [3:0]   ovf_u;
  logic [0:0]   ovf_s, ovf_o;

  assign x_u = {bx[3], bx[2], bx[1], bx[0]};
  assign y_u = {by[3], by[2], by[1], by[0]};
  assign x_s = bx[4];
  assign y_s = by[4];
  assign x_o = bx[5];
  assign y_o = by[5];

  dsp_n_mult_acc #(.CHANNELS(4), .SIGNED(1'b0), .ACC_WIDTH(44), .LATENCY(L)) dut_u (
    .clk(clk), .sclr(sclr), .ena(ena), .din_valid(din_valid), .din_load(din_load),
    .x(x_u), .y(y_u), .dout_valid(dv_u), .dout(dout_u), .overflow(ovf_u));
  dsp_n_mult_acc #(.CHANNELS(1), .SIGNED(1'b1), .ACC_WIDTH(44), .LATENCY(L)) dut_s (
    .clk(clk), .sclr(sclr), .ena(ena), .din_valid(din_valid), .din_load(din_load),
    .x(x_s), .y(y_s), .dout_valid(dv_s), .dout(dout_s), .overflow(ovf_s));
  dsp_n_mult_acc #(.CHANNELS(1), .SIGNED(1'b0), .ACC_WIDTH(36), .LATENCY(L)) dut_o (
    .clk(clk), .sclr(sclr), .ena(ena), .din_valid(din_valid), .din_load(din_load),
    .x(x_o), .y(y_o), .dout_valid(dv_o), .dout(dout_o), .overflow(ovf_o));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_dout(input int l);
    if (l < 4)       return 64'(dout_u[l*44 +: 44]);
    else if (l == 4) return 64'(dout_s);
    else             return 64'(dout_o);
  endfunction

  function automatic logic lane_ovf(input int l);
    if (l < 4)       return ovf_u[l];
    else if (l == 4) return ovf_s[0];
    else             return ovf_o[0];
  endfunction

  function automatic logic lane_dv(input int l);
    if (l < 4)       return dv_u;
    else if (l == 4) return dv_s;
    else             return dv_o;
  endfunction

  function automatic int lane_aw(input int l);
    return (l == 5) ? 36 : 44;
  endfunction

  task automatic clear_data();
    for (int i = 0; i < 6; i++) begin
      bx[i] = '0;
      by[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single sample on one lane, then wait (bounded) for its result.
  task automatic send_check(input int lane, input logic ld, input logic [17:0] xv,
                            input logic [17:0] yv, input logic [63:0] exp,
                            input logic eovf, input string name);
    int n;
    clear_data();
    bx[lane] = xv; by[lane] = yv;
    ena = 1'b1; din_valid = 1'b1; din_load = ld;
    tick();
    din_valid = 1'b0; din_load = 1'b0;
    clear_data();
    n = 0;
    while (!lane_dv(lane) && n < 12) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(L-1));
    check({name, " dout"}, lane_dout(lane), exp);
    check({name, " ovf"}, 64'(lane_ovf(lane)), 64'(eovf));
  endtask

  typedef struct {
    int          lane;
    logic        ld;
    logic [17:0] xv;
    logic [17:0] yv;
    logic [63:0] exp;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vt [14];

  // Reference model: samples queued with the enabled-cycle count at which they retire.
  typedef struct {
    logic [17:0] xv [6];
    logic [17:0] yv [6];
    logic        ld;
    int          due;
  } smp_t;

  smp_t        q [$];
  logic [63:0] m_acc [6];
  logic        m_ovf [6];
  logic        exp_dv;
  int          ecnt;

  task automatic model_apply(input int l, input logic [17:0] xv, input logic [17:0] yv,
                             input logic ld);
    int          aw;
    logic [63:0] mask;
    longint      p, sa, t, lim;
    logic [63:0] up, ut;
    aw   = lane_aw(l);
    mask = (64'd1 << aw) - 64'd1;
    if (l == 4) begin
      p   = longint'($signed(xv)) * longint'($signed(yv));
      sa  = m_acc[l][aw-1] ? longint'(m_acc[l]) - (longint'(1) << aw) : longint'(m_acc[l]);
      lim = longint'(1) << (aw - 1);
      if (ld) begin
        m_acc[l] = 64'(p) & mask;
        m_ovf[l] = 1'b0;
      end else begin
        t = sa + p;
        if (t > lim - 1 || t < -lim) m_ovf[l] = 1'b1;
        m_acc[l] = 64'(t) & mask;
      end
    end else begin
      up = 64'(xv) * 64'(yv);
      if (ld) begin
        m_acc[l] = up;
        m_ovf[l] = 1'b0;
      end else begin
        ut = m_acc[l] + up;
        if ((ut >> aw) != 64'd0) m_ovf[l] = 1'b1;
        m_acc[l] = ut & mask;
      end
    end
  endtask

  task automatic model_edge();
    smp_t s;
    if (sclr) begin
      q.delete();
      ecnt   = 0;
      exp_dv = 1'b0;
      for (int l = 0; l < 6; l++) begin
        m_acc[l] = '0;
        m_ovf[l] = 1'b0;
      end
    end else if (ena) begin
      ecnt++;
      if (din_valid) begin
        s.xv = bx; s.yv = by; s.ld = din_load; s.due = ecnt + L - 1;
        q.push_back(s);
      end
      exp_dv = 1'b0;
      if (q.size() > 0 && q[0].due == ecnt) begin
        s = q.pop_front();
        exp_dv = 1'b1;
        for (int l = 0; l < 6; l++) model_apply(l, s.xv[l], s.yv[l], s.ld);
      end
    end
  endtask

  function automatic logic [17:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 18'h3FFFF;
      1:       return 18'h20000;
      2:       return 18'h0;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    int nsamp, cyc;
    logic [5:0] pat;
    int en_cnt;

    vt[0]  = '{0, 1'b1, 18'd100,     18'd200,     64'd20000,            1'b0, "acc load"};
    vt[1]  = '{0, 1'b0, 18'd7,       18'd9,       64'd20063,            1'b0, "acc add1"};
    vt[2]  = '{0, 1'b0, 18'd1,       18'd1,       64'd20064,            1'b0, "acc add2"};
    vt[3]  = '{4, 1'b1, 18'h3FFFD,   18'd4,       64'hFFF_FFFF_FFF4,    1'b0, "sgn load"};
    vt[4]  = '{4, 1'b0, 18'h20000,   18'h20000,   64'h3_FFFF_FFF4,      1'b0, "sgn add"};
    vt[5]  = '{4, 1'b1, 18'h3FFFF,   18'd1,       64'hFFF_FFFF_FFFF,    1'b0, "sgn neg1"};
    vt[6]  = '{4, 1'b1, 18'h20000,   18'h1FFFF,   64'hFFC_0002_0000,    1'b0, "sgn minmax"};
    vt[7]  = '{5, 1'b1, 18'h3FFFF,   18'h3FFFF,   64'hF_FFF8_0001,      1'b0, "ovf load"};
    vt[8]  = '{5, 1'b0, 18'h3FFFF,   18'h3FFFF,   64'hF_FFF0_0002,      1'b1, "ovf wrap"};
    vt[9]  = '{5, 1'b0, 18'd0,       18'd0,       64'hF_FFF0_0002,      1'b1, "ovf sticky1"};
    vt[10] = '{5, 1'b0, 18'd0,       18'd5,       64'hF_FFF0_0002,      1'b1, "ovf sticky2"};
    vt[11] = '{5, 1'b1, 18'd2,       18'd3,       64'd6,                1'b0, "ovf clear"};
    vt[12] = '{3, 1'b1, 18'h3FFFF,   18'h3FFFF,   64'hF_FFF8_0001,      1'b0, "lane3 load"};
    vt[13] = '{3, 1'b0, 18'h3FFFF,   18'h3FFFF,   64'h1F_FFF0_0002,     1'b0, "lane3 add"};

    clear_data();
    sclr = 1'b1; ena = 1'b1; din_valid = 1'b0; din_load = 1'b0;
    tick(); tick();
    sclr = 1'b0;
    check("reset dout_u", 64'(dout_u[63:0]), 64'd0);
    check("reset dout_s", 64'(dout_s), 64'd0);
    check("reset dout_o", 64'(dout_o), 64'd0);
    check("reset valid", 64'({dv_u, dv_s, dv_o}), 64'd0);
    check("reset ovf", 64'({ovf_u, ovf_s, ovf_o}), 64'd0);

    // First sample after reset: nothing visible before LATENCY-1 edges.
    bx[0] = 18'd3; by[0] = 18'd5; din_valid = 1'b1; din_load = 1'b1;
    tick();
    din_valid = 1'b0; din_load = 1'b0; clear_data();
    for (int e = 1; e <= L - 1; e++) begin
      tick();
      if (e < L - 1) begin
        check("first early valid", 64'(dv_u), 64'd0);
        check("first early dout", lane_dout(0), 64'd0);
      end else begin
        check("first valid", 64'(dv_u), 64'd1);
        check("first dout", lane_dout(0), 64'd15);
      end
    end
    tick();
    check("first valid drop", 64'(dv_u), 64'd0);
    check("first dout hold", lane_dout(0), 64'd15);

    for (int i = 0; i < 14; i++)
      send_check(vt[i].lane, vt[i].ld, vt[i].xv, vt[i].yv, vt[i].exp, vt[i].ovf, vt[i].name);

    // Back-to-back accumulate: results on consecutive cycles.
    bx[0] = 18'd100; by[0] = 18'd200; din_valid = 1'b1; din_load = 1'b1; tick();
    bx[0] = 18'd7;   by[0] = 18'd9;   din_load = 1'b0; tick();
    bx[0] = 18'd1;   by[0] = 18'd1;   tick();
    din_valid = 1'b0; clear_data();
    tick();
    check("b2b r0 valid", 64'(dv_u), 64'd1);
    check("b2b r0 dout", lane_dout(0), 64'd20000);
    tick();
    check("b2b r1 valid", 64'(dv_u), 64'd1);
    check("b2b r1 dout", lane_dout(0), 64'd20063);
    tick();
    check("b2b r2 valid", 64'(dv_u), 64'd1);
    check("b2b r2 dout", lane_dout(0), 64'd20064);
    check("b2b ovf", 64'(ovf_u[0]), 64'd0);
    tick();
    check("b2b tail valid", 64'(dv_u), 64'd0);

    // ena gaps: latency counts enabled edges only; outputs hold while disabled.
    bx[0] = 18'd11; by[0] = 18'd13; din_valid = 1'b1; din_load = 1'b1; tick();
    din_valid = 1'b0; din_load = 1'b0; clear_data();
    pat = 6'b101010;
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      ena = pat[i];
      tick();
      if (pat[i]) en_cnt++;
      check("ena gap valid", 64'(dv_u), 64'(en_cnt == L - 1));
    end
    check("ena gap dout", lane_dout(0), 64'd143);
    ena = 1'b0; tick();
    check("ena hold valid", 64'(dv_u), 64'd1);
    check("ena hold dout", lane_dout(0), 64'd143);
    ena = 1'b1; tick();
    check("ena resume valid", 64'(dv_u), 64'd0);
    check("ena resume dout", lane_dout(0), 64'd143);

    // sclr with LATENCY-1 samples in flight.
    bx[0] = 18'd9; by[0] = 18'd9; din_valid = 1'b1; din_load = 1'b1;
    for (int i = 0; i < L - 1; i++) tick();
    din_valid = 1'b0; din_load = 1'b0; clear_data();
    sclr = 1'b1; tick();
    sclr = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      check("sclr flush valid", 64'(dv_u), 64'd0);
      check("sclr flush dout", lane_dout(0), 64'd0);
      tick();
    end
    send_check(0, 1'b1, 18'd3, 18'd7, 64'd21, 1'b0, "sclr reload");

    // Randomized run against the queue model.
    sclr = 1'b1; ena = 1'b1; din_valid = 1'b0;
    @(posedge clk); model_edge(); #1;
    sclr = 1'b0;
    nsamp = 0;
    cyc = 0;
    while (nsamp < 10000 && cyc < 60000) begin
      sclr      = ($urandom_range(0, 2999) == 0);
      ena       = ($urandom_range(0, 9) < 8);
      din_valid = ($urandom_range(0, 9) < 7);
      din_load  = ($urandom_range(0, 149) == 0);
      for (int l = 0; l < 6; l++) begin
        bx[l] = rnd_op();
        by[l] = rnd_op();
      end
      if (!sclr && ena && din_valid) nsamp++;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("rnd valid_u", 64'(dv_u), 64'(exp_dv));
      check("rnd valid_s", 64'(dv_s), 64'(exp_dv));
      check("rnd valid_o", 64'(dv_o), 64'(exp_dv));
      for (int l = 0; l < 6; l++) begin
        check($sformatf("rnd dout lane%0d", l), lane_dout(l), m_acc[l]);
        check($sformatf("rnd ovf lane%0d", l), 64'(lane_ovf(l)), 64'(m_ovf[l]));
      end
    end
    check("rnd sample count", 64'(nsamp >= 10000), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
